seed_noise_gen: RTL
===================

Name: seed_noise_gen

Overview:
- Consumes the 32-bit seed word delivered into the user_clk domain by the software-writable seed register.
- Produces a seeded Galois-LFSR pseudo-random sample stream for BAO correlator test-vector injection.
- A seed is accepted only after it has been stable for a settle window. It is applied only on an upstream sync pulse, so that reseeding is aligned to spectrum boundaries.

Parameters:
- OUT_W, 8, output sample width (1..32); sample = low OUT_W bits of LFSR state.
- POLY, 32'h80200003, right-shift Galois feedback mask (x^32+x^22+x^2+x+1).
- SETTLE, 3, consecutive unchanged cycles required before a new seed becomes pending (1..15).

Ports:
- user_clk  in  1  single clock for all logic.
- user_rst_n  in  1  reset, asynchronous assert, active-low.
- seed_in  in  32  seed word from the seed register user_data_out.
- sync_in  in  1  one-cycle spectrum-boundary pulse.
- en  in  1  advance enable.
- dout  out  OUT_W  noise sample.
- dout_valid  out  1  dout holds a fresh sample this cycle.
- sync_out  out  1  sync_in aligned to the first sample after it.
- seed_loaded  out  1  one-cycle pulse when a pending seed is applied.
- sample_cnt  out  32  samples since last load (feature-dependent).

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, sync_out=0, seed_loaded=0, sample_cnt=0.
  - lfsr=32'h1, shadow=0, stab_cnt=0, pend=0, pend_seed=0, state=IDLE.
- Seed tracker, evaluated every cycle in any state:
  - seed_in != shadow: shadow<=seed_in, stab_cnt<=0.
  - Otherwise, if stab_cnt<SETTLE, stab_cnt increments.
  - When stab_cnt reaches SETTLE-1 with seed_in==shadow: pend_seed<=shadow, pend<=1. This happens once per distinct value; stab_cnt then saturates at SETTLE.
  - A change before the count completes restarts the count. It does not clear an existing pend; a later stable value overwrites pend_seed.
- Zero-seed rule: a seed of 0 is loaded as 32'h1 (avoids LFSR lockup).
- LFSR step function: step(s) = s[0] ? (s>>1)^POLY : (s>>1).
- FSM states:
  - IDLE: dout_valid=0. On sync_in, load: lfsr<=pend ? pend_seed : shadow (zero rule applied), dout<=same value[OUT_W-1:0], dout_valid<=en, sync_out<=1, seed_loaded<=pend, pend<=0. Go to RUN.
  - RUN, sync_in with pend=1: perform the same load as in IDLE; stay in RUN.
  - RUN, sync_in with pend=0: no reload; lfsr steps if en; sync_out<=1.
  - RUN, no sync_in, en=1: lfsr<=step(lfsr), dout<=step(lfsr)[OUT_W-1:0], dout_valid<=1.
  - RUN, no sync_in, en=0: lfsr and dout hold, dout_valid<=0.
- Latency: one cycle from sync_in to sync_out. The sample that accompanies sync_out after a load is the seed's low bits.
- Simultaneous sync_in and the cycle that would set pend: the new seed is not used; it loads at the next sync_in.
- sync_out, seed_loaded and dout_valid are registered; there are no combinational input-to-output paths.
- Reset mid-operation returns immediately to the reset values. Any pending seed is lost; the tracker re-qualifies seed_in after reset.

Optional Feature:
- NOISE_STATS_EN defined:
  - sample_cnt is a 32-bit counter, cleared to 0 on every load and on reset.
  - It increments on each cycle where dout_valid is set (including the load cycle's sample, counted as 1) and saturates at 32'hFFFFFFFF.
- NOISE_STATS_EN undefined: sample_cnt is tied to 0, no counter logic is inferred, and the port list is unchanged.

Decomposition:
- Package seed_noise_pkg holds:
  - state enum {IDLE, RUN};
  - DEFAULT_POLY and DEFAULT_SETTLE constants;
  - ZERO_SEED_SUB=32'h1.
- Sub-module galois_lfsr_step: a purely combinational next-state function of (s, POLY), reused for any multi-step variant.

Test Plan:
- Reset, then seed_in=0x00000001 held 5 cycles, sync_in pulse, en=1 -> sync_out and seed_loaded high on the next cycle. dout sequence (OUT_W=8) is 0x01, 0x03, 0x02, 0x01. lfsr is 0x80200003, then 0xC0300002, then 0x60180001.
- seed_in=0, pend set, sync_in -> loaded state is 32'h1; sequence is identical to the first scenario.
- Toggle seed_in between 0xAAAA0000 and 0x5555 every 2 cycles with SETTLE=3, issuing sync_in -> seed_loaded=0, and the stream continues uninterrupted from the prior seed.
- While in RUN, new seed stable for 3 cycles and sync_in in the same cycle pend sets -> no reload. The next sync_in reloads with seed_loaded=1.
- en=0 for 4 cycles mid-stream -> dout_valid=0 and dout frozen. On resume, the next value is step() of the held state.
- With NOISE_STATS_EN: load, then 10 valid cycles -> sample_cnt=10; a reload clears it to 0. Assert user_rst_n=0 mid-run -> all outputs are 0 asynchronously.

Source files
------------

// File: rtl/seed_noise_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seed_noise_pkg
//  Description : Shared state encoding, default constants and the zero-seed
//                substitution helper for the seeded noise generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package seed_noise_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shift Galois form
    localparam logic [31:0] DEFAULT_POLY   = 32'h8020_0003;
    localparam int          DEFAULT_SETTLE = 3;
    localparam logic [31:0] ZERO_SEED_SUB  = 32'h0000_0001;

    // An all-zero state would lock the LFSR, so it is never loaded.
    function automatic logic [31:0] apply_zero_rule(input logic [31:0] seed);
        return (seed == 32'h0) ? ZERO_SEED_SUB : seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/galois_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : galois_lfsr_step
//  Description : Combinational single-step next-state function of a 32-bit
//                right-shift Galois LFSR with feedback mask POLY.
//  Revision    : 1.0 - initial release
// ============================================================================
module galois_lfsr_step
    import seed_noise_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic [31:0] i_state,
    output logic [31:0] o_state_next
);

    logic [31:0] w_shifted;

    assign w_shifted    = i_state >> 1;
    assign o_state_next = i_state[0] ? (w_shifted ^ POLY) : w_shifted;

endmodule
`default_nettype wire

// File: rtl/seed_noise_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seed_noise_gen
//  Description : Seeded Galois-LFSR noise source. Seeds are qualified by a
//                stability window and applied only on sync_in pulses.
//                Build option: NOISE_STATS_EN enables the sample_cnt counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seed_noise_gen
    import seed_noise_pkg::*;
#(
    parameter int          OUT_W  = 8,
    parameter logic [31:0] POLY   = DEFAULT_POLY,
    parameter int          SETTLE = DEFAULT_SETTLE
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [31:0]      seed_in,
    input  logic             sync_in,
    input  logic             en,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             sync_out,
    output logic             seed_loaded,
    output logic [31:0]      sample_cnt
);

    localparam logic [3:0] c_settle    = 4'(SETTLE);
    localparam logic [3:0] c_settle_m1 = 4'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_lfsr;
    logic [31:0]      r_shadow;
    logic [3:0]       r_stab_cnt;
    logic             r_pend;
    logic [31:0]      r_pend_seed;
    logic [OUT_W-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_sync_out;
    logic             r_seed_loaded;

    logic             w_load;
    logic [31:0]      w_load_seed;
    logic [31:0]      w_lfsr_step;
    logic             w_seed_same;
    logic             w_pend_set;
    logic [3:0]       w_stab_cnt_nxt;
    logic [31:0]      w_lfsr_nxt;
    logic [OUT_W-1:0] w_dout_nxt;
    logic             w_dout_valid_nxt;
    logic             w_sync_out_nxt;
    logic             w_seed_loaded_nxt;
    logic             w_pend_nxt;
    logic [31:0]      w_pend_seed_nxt;

    galois_lfsr_step #(
        .POLY (POLY)
    ) u_step (
        .i_state      (r_lfsr),
        .o_state_next (w_lfsr_step)
    );

    assign w_load_seed = apply_zero_rule(r_pend ? r_pend_seed : r_shadow);

    // Seed tracker runs regardless of FSM state.
    assign w_seed_same = (seed_in == r_shadow);
    assign w_pend_set  = w_seed_same && (r_stab_cnt == c_settle_m1);

    always_comb begin
        w_stab_cnt_nxt = r_stab_cnt;
        if (!w_seed_same) begin
            w_stab_cnt_nxt = 4'd0;
        end else if (r_stab_cnt < c_settle) begin
            w_stab_cnt_nxt = r_stab_cnt + 4'd1;
        end
    end

    // Next-state logic; w_load marks a seed application this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (sync_in) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_load = sync_in && r_pend;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_lfsr_nxt        = r_lfsr;
        w_dout_nxt        = r_dout;
        w_dout_valid_nxt  = 1'b0;
        w_sync_out_nxt    = 1'b0;
        w_seed_loaded_nxt = 1'b0;
        w_pend_nxt        = r_pend;
        w_pend_seed_nxt   = r_pend_seed;

        if (w_load) begin
            w_lfsr_nxt        = w_load_seed;
            w_dout_nxt        = w_load_seed[OUT_W-1:0];
            w_dout_valid_nxt  = en;
            w_sync_out_nxt    = 1'b1;
            w_seed_loaded_nxt = r_pend;
            w_pend_nxt        = 1'b0;
        end else if (r_state == RUN) begin
            w_sync_out_nxt = sync_in;
            if (en) begin
                w_lfsr_nxt       = w_lfsr_step;
                w_dout_nxt       = w_lfsr_step[OUT_W-1:0];
                w_dout_valid_nxt = 1'b1;
            end
        end

        // A seed qualifying in the same cycle as a load waits for the next sync.
        if (w_pend_set) begin
            w_pend_nxt      = 1'b1;
            w_pend_seed_nxt = r_shadow;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state       <= IDLE;
            r_lfsr        <= 32'h1;
            r_shadow      <= 32'h0;
            r_stab_cnt    <= 4'd0;
            r_pend        <= 1'b0;
            r_pend_seed   <= 32'h0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_sync_out    <= 1'b0;
            r_seed_loaded <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lfsr        <= w_lfsr_nxt;
            r_shadow      <= seed_in;
            r_stab_cnt    <= w_stab_cnt_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_seed   <= w_pend_seed_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_valid  <= w_dout_valid_nxt;
            r_sync_out    <= w_sync_out_nxt;
            r_seed_loaded <= w_seed_loaded_nxt;
        end
    end

`ifdef NOISE_STATS_EN
    logic [31:0] r_sample_cnt;

    // Load restarts the count; the load's own sample counts when en is high.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_sample_cnt <= 32'h0;
        end else if (w_load) begin
            r_sample_cnt <= {31'h0, en};
        end else if (w_dout_valid_nxt && (r_sample_cnt != 32'hFFFF_FFFF)) begin
            r_sample_cnt <= r_sample_cnt + 32'h1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`else
    assign sample_cnt = 32'h0;
`endif

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign sync_out    = r_sync_out;
    assign seed_loaded = r_seed_loaded;

endmodule
`default_nettype wire
